// File: rtl/eth_mac_tx_rr_mux_if.sv
// AXI-stream bundle between the CHANNELS TX sources, the round-robin merge and the MAC-side sink.
// The mux uses the slave modport; the environment driving sources and sinking the merged stream uses master.
interface eth_mac_tx_rr_mux_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int CH_W       = $clog2(CHANNELS)
);
  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [CHANNELS-1:0]            s_axis_tvalid;
  logic [CHANNELS-1:0]            s_axis_tready;
  logic [CHANNELS-1:0]            s_axis_tlast;
  logic [CHANNELS*USER_WIDTH-1:0] s_axis_tuser;
  logic [DATA_WIDTH-1:0]          m_axis_tdata;
  logic                           m_axis_tvalid;
  logic                           m_axis_tready;
  logic                           m_axis_tlast;
  logic [USER_WIDTH-1:0]          m_axis_tuser;
  logic [CH_W-1:0]                m_axis_tid;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid
  );
endinterface

// File: rtl/eth_mac_tx_rr_mux.sv
// Frame-granular round-robin merge of CHANNELS TX streams with frame-length and stall guards.
// Optional per-channel completed-frame counters are enabled by defining ETH_TX_RR_MUX_STATS_EN.
module eth_mac_tx_rr_mux #(
  parameter int CHANNELS      = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int USER_WIDTH    = 1,
  parameter int MAX_FRAME_LEN = 1522,
  parameter int STALL_TIMEOUT = 16,
  parameter int CH_W          = $clog2(CHANNELS)
) (
  input  logic                    tx_clk,
  input  logic                    tx_rst,
  eth_mac_tx_rr_mux_if.slave      axis,
  output logic                    stat_truncated,
  output logic                    stat_timeout,
  output logic [CHANNELS*32-1:0]  stat_frame_count
);

  localparam int CNT_W = $clog2(MAX_FRAME_LEN + 1);
  localparam int ST_W  = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [CH_W-1:0]        grant, ptr, pick, cand;
  logic                   any_req;
  logic [CNT_W-1:0]       beat_cnt;
  logic [ST_W-1:0]        stall_cnt;
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_valid, out_last;
  logic [USER_WIDTH-1:0]  out_user, last_user;
  logic [CH_W-1:0]        out_id;
  logic [CHANNELS-1:0]    s_ready;
  logic [DATA_WIDTH-1:0]  ch_data [CHANNELS];
  logic [USER_WIDTH-1:0]  ch_user [CHANNELS];
  logic                   ld, g_valid, g_last, stalled, take, synth, trunc;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ch_data[i] = axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      ch_user[i] = axis.s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
    end
  end

  assign ld      = !out_valid | axis.m_axis_tready;
  assign g_valid = axis.s_axis_tvalid[grant];
  assign g_last  = axis.s_axis_tlast[grant];
  assign stalled = (stall_cnt == ST_W'(STALL_TIMEOUT));

  // First requester strictly after the last winner, wrapping around
  always_comb begin
    pick    = ptr;
    cand    = ptr;
    any_req = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = CH_W'((int'(ptr) + k) % CHANNELS);
      if (!any_req && axis.s_axis_tvalid[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACTIVE;
      ACTIVE: begin
        if (take)       state_nxt = g_last ? IDLE : (trunc ? DRAIN : ACTIVE);
        else if (synth) state_nxt = DRAIN;
      end
      DRAIN:   if (g_valid && g_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A real beat always beats a pending timeout, since synth needs granted tvalid low
  always_comb begin
    s_ready = '0;
    take    = 1'b0;
    synth   = 1'b0;
    trunc   = 1'b0;
    case (state)
      ACTIVE: begin
        s_ready[grant] = ld;
        take  = ld && g_valid;
        trunc = take && !g_last && (beat_cnt == CNT_W'(MAX_FRAME_LEN - 1));
        synth = ld && !g_valid && stalled;
      end
      DRAIN:   s_ready[grant] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      grant          <= '0;
      ptr            <= CH_W'(CHANNELS - 1);
      beat_cnt       <= '0;
      stall_cnt      <= '0;
      last_user      <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_user       <= '0;
      out_id         <= '0;
      stat_truncated <= 1'b0;
      stat_timeout   <= 1'b0;
    end else begin
      stat_truncated <= trunc;
      stat_timeout   <= synth;
      if (state == IDLE && any_req) begin
        grant     <= pick;
        ptr       <= pick;
        beat_cnt  <= '0;
        stall_cnt <= '0;
      end
      if (take) begin
        beat_cnt  <= beat_cnt + 1'b1;
        stall_cnt <= '0;
        last_user <= ch_user[grant];
      end else if (state == ACTIVE && !g_valid && !stalled) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ld) begin
        out_valid <= take | synth;
        if (take) begin
          out_data <= ch_data[grant];
          out_last <= g_last | trunc;
          out_user <= ch_user[grant] | USER_WIDTH'(trunc);
          out_id   <= grant;
        end else if (synth) begin
          out_data <= '0;
          out_last <= 1'b1;
          out_user <= last_user | USER_WIDTH'(1);
          out_id   <= grant;
        end
      end
    end
  end

  assign axis.s_axis_tready = s_ready;
  assign axis.m_axis_tdata  = out_data;
  assign axis.m_axis_tvalid = out_valid;
  assign axis.m_axis_tlast  = out_last;
  assign axis.m_axis_tuser  = out_user;
  assign axis.m_axis_tid    = out_id;

`ifdef ETH_TX_RR_MUX_STATS_EN
  logic [31:0] frame_cnt [CHANNELS];

  // Only frames that end on their own tlast are counted; cut or aborted ones are not
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      for (int i = 0; i < CHANNELS; i++) frame_cnt[i] <= '0;
    end else if (take && g_last) begin
      frame_cnt[grant] <= frame_cnt[grant] + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) stat_frame_count[i*32 +: 32] = frame_cnt[i];
  end
`else
  assign stat_frame_count = '0;
`endif

endmodule
